// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding req/gnt/rvalid fetch FSM and IF/ID pipeline register.
// Latency: a granted fetch reaches Instruction_id one edge after rvalid. At most one instruction every 2 cycles.
// Backpressure: IFWrite=0 freezes PC and IF/ID. A response that arrives during the stall is parked in a one-word buffer.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   IFWrite, Branch, Jump       ID-stage stall and redirect controls
//   JumpAddr                    redirect target (bits [1:0] ignored)
//   imem_req/addr/gnt           fetch request handshake
//   imem_rvalid/rdata           fetch response
//   Instruction_id/PC_id/Valid_id  IF/ID register towards decode
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        Valid_id
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state;
    logic [29:0] pc_word;   // word address; byte bits are implicitly 00
    logic [31:0] buffer;

    logic        redirect;
    logic        deliver_mem;
    logic        deliver_buf;
    logic        deliver;
    logic [31:0] deliver_dat;
    logic        unused_jump_lsbs;

    // Branch/Jump sampled during a stall carry stale operands, so they only
    // take effect together with IFWrite.
    assign redirect    = (Branch | Jump) & IFWrite;
    assign deliver_mem = (state == S_WAIT) & imem_rvalid & IFWrite & ~redirect;
    assign deliver_buf = (state == S_FULL) & IFWrite & ~redirect;
    assign deliver     = deliver_mem | deliver_buf;
    assign deliver_dat = deliver_buf ? buffer : imem_rdata;

    // No request while redirecting: the current pc is about to be replaced.
    assign imem_req  = (state == S_FETCH) & ~redirect;
    assign imem_addr = {pc_word, 2'b00};

    assign unused_jump_lsbs = ^JumpAddr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_FETCH;
            pc_word        <= RESET_PC[31:2];
            buffer         <= NOP_INSTR;
            Instruction_id <= NOP_INSTR;
            PC_id          <= 32'h0000_0000;
            Valid_id       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect || IFWrite) begin
                            state <= S_FETCH;
                        end else begin
                            buffer <= imem_rdata;
                            state  <= S_FULL;
                        end
                    end else if (redirect) begin
                        // Response still in flight for the old path; swallow it later.
                        state <= S_DROP;
                    end
                end
                S_FULL: begin
                    // Either delivered or discarded by a redirect; both free the buffer.
                    if (IFWrite) begin
                        state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase

            if (redirect) begin
                pc_word <= JumpAddr[31:2];
            end else if (deliver) begin
                pc_word <= pc_word + 30'd1;   // wraps 0xFFFF_FFFC -> 0
            end

            if (IFWrite) begin
                if (deliver) begin
                    Instruction_id <= deliver_dat;
                    PC_id          <= {pc_word, 2'b00};
                    Valid_id       <= 1'b1;
                end else begin
                    // Flush and empty bubble look the same; PC_id keeps its last value.
                    Instruction_id <= NOP_INSTR;
                    Valid_id       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFWrite, Branch, Jump;
    logic [31:0] JumpAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_id, PC_id;
    logic        Valid_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .Valid_id       (Valid_id)
    );

    typedef struct packed {
        logic        ifw, br, jp;
        logic [31:0] ja;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pcid, ins;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc, ins;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ifw, br, jp, input logic [31:0] ja,
                                input logic gnt, rv, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pcid, ins);
        vec_t v;
        v.ifw = ifw; v.br = br; v.jp = jp; v.ja = ja;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.req = req; v.addr = addr; v.vld = vld; v.pcid = pcid; v.ins = ins;
        return v;
    endfunction

    task automatic drive(input logic ifw, br, jp, input logic [31:0] ja,
                         input logic gnt, rv, input logic [31:0] rd);
        IFWrite = ifw; Branch = br; Jump = jp; JumpAddr = ja;
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_ifid(input string name, input logic vld, input logic [31:0] pcid, ins);
        chk({name, " Valid_id"}, {31'b0, Valid_id}, {31'b0, vld});
        chk({name, " PC_id"}, PC_id, pcid);
        chk({name, " Instruction_id"}, Instruction_id, ins);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        drive(v.ifw, v.br, v.jp, v.ja, v.gnt, v.rv, v.rd);
        #1;
        chk($sformatf("v%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.req});
        chk($sformatf("v%0d imem_addr", idx), imem_addr, v.addr);
        tick();
        chk_ifid($sformatf("v%0d", idx), v.vld, v.pcid, v.ins);
    endtask

    initial begin
        logic        pend;
        int          lat;
        logic [31:0] pdata;
        logic [31:0] exp_fetch;
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic        allow;
        logic        granted;
        int          delivered;
        exp_t        e;

        //  ifw br jp ja            gnt rv rd             req addr           vld pcid           ins
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h000,        0,32'h000,        NOP));          // 0 first fetch
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h100,        0,32'h000,        1,32'h000,        32'h100));      // 1
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h004,        0,32'h000,        NOP));          // 2
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h101,        0,32'h004,        1,32'h004,        32'h101));      // 3
        vt.push_back(mk(0,0,0,32'h0,  1,0,32'h0,          1,32'h008,        1,32'h004,        32'h101));      // 4 stall, grant
        vt.push_back(mk(0,0,0,32'h0,  0,1,32'h102,        0,32'h008,        1,32'h004,        32'h101));      // 5 response buffered
        vt.push_back(mk(0,0,0,32'h0,  0,0,32'h0,          0,32'h008,        1,32'h004,        32'h101));      // 6 FULL
        vt.push_back(mk(0,0,0,32'h0,  1,0,32'h0,          0,32'h008,        1,32'h004,        32'h101));      // 7 gnt ignored
        vt.push_back(mk(1,0,0,32'h0,  0,0,32'h0,          0,32'h008,        1,32'h008,        32'h102));      // 8 buffer out
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h00C,        0,32'h008,        NOP));          // 9
        vt.push_back(mk(1,0,1,32'h203,0,0,32'h0,          0,32'h00C,        0,32'h008,        NOP));          // 10 jump in WAIT
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'hDEAD,       0,32'h200,        0,32'h008,        NOP));          // 11 stale dropped
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h200,        0,32'h008,        NOP));          // 12
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h180,        0,32'h200,        1,32'h200,        32'h180));      // 13
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h204,        0,32'h200,        NOP));          // 14
        vt.push_back(mk(1,1,0,32'h40, 0,1,32'hBAD,        0,32'h204,        0,32'h200,        NOP));          // 15 rvalid+redirect
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h040,        0,32'h200,        NOP));          // 16
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h11,         0,32'h040,        1,32'h040,        32'h11));       // 17
        vt.push_back(mk(0,1,0,32'h300,0,0,32'h0,          1,32'h044,        1,32'h040,        32'h11));       // 18 branch ignored
        vt.push_back(mk(1,1,0,32'h300,1,0,32'h0,          0,32'h044,        0,32'h040,        NOP));          // 19 branch taken
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h300,        0,32'h040,        NOP));          // 20
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h22,         0,32'h300,        1,32'h300,        32'h22));       // 21
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h304,        0,32'h300,        NOP));          // 22
        vt.push_back(mk(0,0,0,32'h0,  0,1,32'h33,         0,32'h304,        0,32'h300,        NOP));          // 23 -> FULL
        vt.push_back(mk(1,0,1,32'h400,0,0,32'h0,          0,32'h304,        0,32'h300,        NOP));          // 24 FULL discarded
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h400,        0,32'h300,        NOP));          // 25
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h44,         0,32'h400,        1,32'h400,        32'h44));       // 26
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h404,        0,32'h400,        NOP));          // 27
        vt.push_back(mk(1,0,1,32'h500,0,0,32'h0,          0,32'h404,        0,32'h400,        NOP));          // 28 -> DROP
        vt.push_back(mk(1,1,0,32'h600,0,0,32'h0,          0,32'h500,        0,32'h400,        NOP));          // 29 DROP re-redirect
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h55,         0,32'h600,        0,32'h400,        NOP));          // 30 drop response
        vt.push_back(mk(1,0,0,32'h0,  1,0,32'h0,          1,32'h600,        0,32'h400,        NOP));          // 31
        vt.push_back(mk(1,0,0,32'h0,  0,1,32'h66,         0,32'h600,        1,32'h600,        32'h66));       // 32

        // Reset state
        do_reset();
        chk_ifid("reset", 1'b0, 32'h0, NOP);
        #1;
        chk("reset imem_req", {31'b0, imem_req}, 32'h1);
        chk("reset imem_addr", imem_addr, 32'h0);

        foreach (vt[i]) run_vec(i, vt[i]);

        // PC wrap at the top of the address space and address hold under gnt=0
        drive(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("wrap addr top", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(1, 0, 0, 32'h0, 0, 1, 32'hAA);
        tick();
        chk_ifid("wrap top", 1'b1, 32'hFFFF_FFFC, 32'hAA);
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d req", k), {31'b0, imem_req}, 32'h1);
            chk($sformatf("hold%0d addr", k), imem_addr, 32'h0);
            tick();
        end
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        tick();
        drive(1, 0, 0, 32'h0, 0, 1, 32'hBB);
        tick();
        chk_ifid("wrap zero", 1'b1, 32'h0, 32'hBB);

        // Reset while in WAIT
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        tick();
        reset = 1'b1;
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_wait req", {31'b0, imem_req}, 32'h1);
        chk("rst_wait addr", imem_addr, 32'h0);
        chk_ifid("rst_wait", 1'b0, 32'h0, NOP);

        // Reset while in DROP
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        tick();
        drive(1, 0, 1, 32'h800, 0, 0, 32'h0);
        tick();
        reset = 1'b1;
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_drop req", {31'b0, imem_req}, 32'h1);
        chk("rst_drop addr", imem_addr, 32'h0);
        chk_ifid("rst_drop", 1'b0, 32'h0, NOP);

        // Random-latency stream with random stalls, checked by a scoreboard
        do_reset();
        pend = 1'b0; lat = 0; pdata = 32'h0;
        exp_fetch = 32'h0; prev_wait = 1'b0; prev_addr = 32'h0;
        allow = 1'b1; delivered = 0;
        for (int c = 0; c < 420; c++) begin
            if (c == 400) allow = 1'b0;
            drive(allow ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 1'b0, 32'h0,
                  allow & ($urandom_range(0, 1) == 1), pend && (lat == 0),
                  (pend && (lat == 0)) ? pdata : 32'hDEAD_BEEF);
            #1;
            if (prev_wait) begin
                chk("sb held req", {31'b0, imem_req}, 32'h1);
                chk("sb held addr", imem_addr, prev_addr);
            end
            granted = imem_req & imem_gnt;
            if (granted) begin
                chk("sb fetch addr", imem_addr, exp_fetch);
                e.pc  = exp_fetch;
                e.ins = 32'h100 + {2'b00, exp_fetch[31:2]};
                sbq.push_back(e);
                exp_fetch = exp_fetch + 32'h4;
            end
            prev_wait = imem_req & ~imem_gnt;
            prev_addr = imem_addr;
            tick();
            if (imem_rvalid) pend = 1'b0;
            else if (pend && lat > 0) lat--;
            if (granted) begin
                pend  = 1'b1;
                lat   = $urandom_range(0, 2);
                pdata = 32'h100 + {2'b00, prev_addr[31:2]};
            end
            if (IFWrite && Valid_id) begin
                if (sbq.size() == 0) begin
                    chk("sb unexpected delivery", PC_id, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb PC_id", PC_id, e.pc);
                    chk("sb Instruction_id", Instruction_id, e.ins);
                    delivered++;
                end
            end
        end
        chk("sb drained", sbq.size(), 32'h0);
        chk("sb progress", {31'b0, delivered > 20}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
